mem_arbiter: RTL and testbench

- Shares the single main-memory line port between the instruction-cache refill path and the data-cache refill/writeback path.
- Accepts one request at a time, holds the memory request stable until memory completes, then returns the line to the winning requester with a one-cycle response pulse.
- Sits between the two caches and backing memory, beneath the core pipeline.
- Its per-requester wait outputs feed the icache_stall and dcache_stall control signals.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter_pick.sv | 19 +
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
package mem_arb_pkg;
  localparam int MEM_ARB_LINE_W = 128;
  localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_IC, OWN_DC} arb_owner_t;
  typedef logic [MEM_ARB_LINE_W-1:0] line_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and memory line-port signals around the arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int LINE_W = 128);
  logic ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic ic_resp_valid;
  logic [LINE_W-1:0] ic_rdata;
  logic ic_wait;
  logic dc_req;
  logic dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic dc_resp_valid;
  logic [LINE_W-1:0] dc_rdata;
  logic dc_wait;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic timeout_err;
  modport master (
    input ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
    output ic_resp_valid, ic_rdata, ic_wait, dc_resp_valid, dc_rdata, dc_wait,
    output mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
    input ic_resp_valid, ic_rdata, ic_wait, dc_resp_valid, dc_rdata, dc_wait,
    input mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// arb_pick: winner selection between icache and dcache requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the dcache always wins.
module arb_pick import mem_arb_pkg::*; (
  input logic icReq,
  input logic dcReq,
  output logic anyReq,
  output arb_owner_t grant
`ifdef MEM_ARB_RR_EN
  ,
  input arb_owner_t lastGrant
`endif
);
  always_comb anyReq = icReq | dcReq;
`ifdef MEM_ARB_RR_EN
  always_comb grant = (dcReq && (!icReq || lastGrant == OWN_IC)) ? OWN_DC : OWN_IC;
`else
  always_comb grant = dcReq ? OWN_DC : OWN_IC;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory line port between icache refill and dcache refill/writeback.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dcache priority.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int TIMEOUT = MEM_ARB_TIMEOUT_DEFAULT
) (
  input logic clock,
  input logic reset,
  mem_arbiter_if.master bus
);
  arb_state_t state;
  arb_owner_t owner, pick;
  logic anyReq, weQ, timeoutErr, expired;
  logic [ADDR_W-1:0] addrQ;
  logic [LINE_W-1:0] wdataQ, icData, dcData, rdataNext;
  logic [31:0] cnt;
  always_comb expired = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
  // A timed-out transaction returns all-ones so the stalled cache can proceed.
  always_comb rdataNext = bus.mem_ready ? bus.mem_rdata : '1;
`ifdef MEM_ARB_RR_EN
  arb_owner_t lastGrant;
  arb_pick u_pick (.icReq(bus.ic_req), .dcReq(bus.dc_req), .anyReq, .grant(pick), .lastGrant);
  always_ff @(posedge clock or posedge reset)
    if (reset) lastGrant <= OWN_IC;
    else if (state == IDLE && anyReq) lastGrant <= pick;
`else
  arb_pick u_pick (.icReq(bus.ic_req), .dcReq(bus.dc_req), .anyReq, .grant(pick));
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_IC;
      addrQ <= '0;
      weQ <= 1'b0;
      wdataQ <= '0;
      icData <= '0;
      dcData <= '0;
      cnt <= '0;
      timeoutErr <= 1'b0;
    end else if (state == IDLE) begin
      if (anyReq) begin
        owner <= pick;
        addrQ <= pick == OWN_DC ? bus.dc_addr : bus.ic_addr;
        weQ <= pick == OWN_DC && bus.dc_we;
        wdataQ <= pick == OWN_DC ? bus.dc_wdata : '0;
        state <= BUSY;
      end
    end else if (state == BUSY) begin
      if (bus.mem_ready || expired) begin
        if (owner == OWN_DC) dcData <= rdataNext;
        else icData <= rdataNext;
        timeoutErr <= timeoutErr | ~bus.mem_ready;
        cnt <= '0;
        state <= RESP;
      end else cnt <= cnt + 32'd1;
    end else state <= IDLE;
  end
  assign bus.mem_req = state == BUSY;
  assign bus.mem_we = weQ;
  assign bus.mem_addr = addrQ;
  assign bus.mem_wdata = wdataQ;
  assign bus.ic_resp_valid = state == RESP && owner == OWN_IC;
  assign bus.dc_resp_valid = state == RESP && owner == OWN_DC;
  assign bus.ic_rdata = icData;
  assign bus.dc_rdata = dcData;
  assign bus.ic_wait = bus.ic_req & ~bus.ic_resp_valid;
  assign bus.dc_wait = bus.dc_req & ~bus.dc_resp_valid;
  assign bus.timeout_err = timeoutErr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench with a transaction-level arbiter model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic we;
    line_t d;
    line_t r;
  } memrec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int memLat = 2;
  int memUnstable = 0;
  line_t memPattern = '0;
  memrec_t memLog[$];
  int icCnt, dcCnt, icT, dcT, waitBad, bothPulse, errT;
  bit pendLeft;
  line_t icD, dcD;
  arb_owner_t lastModel = OWN_IC;
  line_t icHold = '0;
  line_t dcHold = '0;

  mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus();
  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  function automatic line_t rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory model: answers memLat cycles into each request (0 = never), logs what it saw.
  initial begin
    bit inTxn;
    int waitCnt;
    memrec_t snap;
    inTxn = 1'b0;
    waitCnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      tick();
      bus.mem_ready = 1'b0;
      if (reset || !bus.mem_req) inTxn = 1'b0;
      else begin
        if (!inTxn) begin
          inTxn = 1'b1;
          waitCnt = 0;
          snap.a = bus.mem_addr;
          snap.we = bus.mem_we;
          snap.d = bus.mem_wdata;
        end else if (bus.mem_addr !== snap.a || bus.mem_we !== snap.we || bus.mem_wdata !== snap.d)
          memUnstable++;
        waitCnt++;
        if (memLat != 0 && waitCnt == memLat) begin
          bus.mem_rdata = memPattern != '0 ? memPattern : rline();
          bus.mem_ready = 1'b1;
          snap.r = bus.mem_rdata;
          memLog.push_back(snap);
        end
      end
    end
  end

  // Requester model: holds each request until its resp_valid pulse, then drops it.
  task automatic run(input bit doIc, input bit doDc, input logic [31:0] ia, input logic [31:0] da,
                     input bit dwe, input line_t dwd, input int budget);
    bit icPend, dcPend;
    int t;
    icPend = doIc;
    dcPend = doDc;
    t = 0;
    icCnt = 0; dcCnt = 0; icT = -1; dcT = -1; waitBad = 0; bothPulse = 0; errT = -1;
    memLog.delete();
    memUnstable = 0;
    bus.ic_addr = ia; bus.dc_addr = da; bus.dc_we = dwe; bus.dc_wdata = dwd;
    bus.ic_req = doIc; bus.dc_req = doDc;
    while ((icPend || dcPend) && t < budget) begin
      tick();
      t++;
      bus.ic_req = icPend;
      bus.dc_req = dcPend;
      #1;
      if (bus.ic_wait !== (icPend && !bus.ic_resp_valid)) waitBad++;
      if (bus.dc_wait !== (dcPend && !bus.dc_resp_valid)) waitBad++;
      if (errT < 0 && bus.timeout_err === 1'b1) errT = t;
      if (bus.ic_resp_valid && bus.dc_resp_valid) bothPulse++;
      if (bus.ic_resp_valid) begin icCnt++; icT = t; icD = bus.ic_rdata; icPend = 1'b0; end
      if (bus.dc_resp_valid) begin dcCnt++; dcT = t; dcD = bus.dc_rdata; dcPend = 1'b0; end
    end
    pendLeft = icPend || dcPend;
    tick();
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    repeat (8) begin
      tick();
      if (bus.ic_resp_valid) icCnt++;
      if (bus.dc_resp_valid) dcCnt++;
    end
  endtask

  // One arbitration round checked against the model's grant order and timing.
  task automatic round(input bit doIc, input bit doDc, input logic [31:0] ia, input logic [31:0] da,
                       input bit dwe, input line_t dwd, input int L, input string tag);
    bit dcFirst;
    int icIdx, dcIdx, expIcT, expDcT;
    dcFirst = doDc && (!doIc || !RR || lastModel == OWN_IC);
    icIdx = (doDc && dcFirst) ? 1 : 0;
    dcIdx = (doIc && !dcFirst) ? 1 : 0;
    expIcT = icIdx == 1 ? 2 * L + 3 : L + 1;
    expDcT = dcIdx == 1 ? 2 * L + 3 : L + 1;
    memLat = L;
    run(doIc, doDc, ia, da, dwe, dwd, 60);
    if (doIc && doDc) lastModel = dcFirst ? OWN_IC : OWN_DC;
    else lastModel = doDc ? OWN_DC : OWN_IC;
    checks++;
    if (icCnt !== int'(doIc) || dcCnt !== int'(doDc)) begin
      failures++;
      $display("FAIL %s_count: ic=%0d dc=%0d want ic=%0d dc=%0d", tag, icCnt, dcCnt, doIc, doDc);
    end
    checks++;
    if (memLog.size() !== int'(doIc) + int'(doDc)) begin
      failures++;
      $display("FAIL %s_memtxns: got %0d want %0d", tag, memLog.size(), int'(doIc) + int'(doDc));
    end
    if (doIc) begin
      checks++;
      if (icT !== expIcT) begin
        failures++;
        $display("FAIL %s_ic_cycle: got %0d want %0d", tag, icT, expIcT);
      end
      if (memLog.size() > icIdx) begin
        checks++;
        if (memLog[icIdx].a !== ia || memLog[icIdx].we !== 1'b0) begin
          failures++;
          $display("FAIL %s_ic_memreq: addr=%h we=%b want addr=%h we=0", tag, memLog[icIdx].a, memLog[icIdx].we, ia);
        end
        checks++;
        if (icD !== memLog[icIdx].r) begin
          failures++;
          $display("FAIL %s_ic_rdata: got %h want %h", tag, icD, memLog[icIdx].r);
        end
        icHold = memLog[icIdx].r;
      end
    end
    if (doDc) begin
      checks++;
      if (dcT !== expDcT) begin
        failures++;
        $display("FAIL %s_dc_cycle: got %0d want %0d", tag, dcT, expDcT);
      end
      if (memLog.size() > dcIdx) begin
        checks++;
        if (memLog[dcIdx].a !== da || memLog[dcIdx].we !== dwe || (dwe && memLog[dcIdx].d !== dwd)) begin
          failures++;
          $display("FAIL %s_dc_memreq: addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   tag, memLog[dcIdx].a, memLog[dcIdx].we, memLog[dcIdx].d, da, dwe, dwd);
        end
        if (!dwe) begin
          checks++;
          if (dcD !== memLog[dcIdx].r) begin
            failures++;
            $display("FAIL %s_dc_rdata: got %h want %h", tag, dcD, memLog[dcIdx].r);
          end
        end
        dcHold = memLog[dcIdx].r;
      end
    end
    checks++;
    if (bus.ic_rdata !== icHold || bus.dc_rdata !== dcHold) begin
      failures++;
      $display("FAIL %s_rdata_hold: ic=%h dc=%h want ic=%h dc=%h", tag, bus.ic_rdata, bus.dc_rdata, icHold, dcHold);
    end
    checks++;
    if (waitBad !== 0 || bothPulse !== 0 || memUnstable !== 0) begin
      failures++;
      $display("FAIL %s_protocol: wait_errs=%0d dual_pulses=%0d unstable=%0d want 0 0 0", tag, waitBad, bothPulse, memUnstable);
    end
  endtask

  task automatic test_reset();
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    bus.ic_addr = '0; bus.dc_addr = '0; bus.dc_wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ic_resp_valid, bus.dc_resp_valid, bus.ic_wait, bus.dc_wait, bus.timeout_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {bus.mem_req, bus.mem_we, bus.ic_resp_valid, bus.dc_resp_valid, bus.ic_wait, bus.dc_wait, bus.timeout_err});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== '0 || bus.ic_rdata !== '0 || bus.dc_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h ic=%h dc=%h want all 0", bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata);
    end
    bus.ic_req = 1'b1;
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.ic_wait !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold: mem_req=%b ic_wait=%b want 0 1", bus.mem_req, bus.ic_wait);
    end
    bus.ic_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ic_refill();
    memPattern = {8{16'hAAAA}};
    round(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, '0, 2, "ic_refill");
    memPattern = '0;
  endtask

  task automatic test_dc_writeback();
    round(1'b0, 1'b1, 32'h0, 32'h2000, 1'b1, {4{32'h12345678}}, 3, "dc_writeback");
  endtask

  task automatic test_simultaneous();
    round(1'b1, 1'b1, $urandom & ~32'hF, $urandom & ~32'hF, 1'b0, rline(), 2, "simultaneous");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++)
      round(1'b1, 1'b1, $urandom & ~32'hF, $urandom & ~32'hF, 1'($urandom), rline(), $urandom_range(2, 4), "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      round(m[0], m[1], $urandom & ~32'hF, $urandom & ~32'hF, 1'($urandom), rline(), $urandom_range(2, 5), "random");
    end
  endtask

  task automatic test_timeout();
    memLat = 0;
    run(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, '0, 30);
    lastModel = OWN_IC;
    icHold = '1;
    checks++;
    if (pendLeft || icCnt !== 1 || dcCnt !== 0 || icT !== TO + 1) begin
      failures++;
      $display("FAIL timeout_resp: ic=%0d dc=%0d cycle=%0d want 1 0 %0d", icCnt, dcCnt, icT, TO + 1);
    end
    checks++;
    if (icD !== {128{1'b1}}) begin
      failures++;
      $display("FAIL timeout_rdata: got %h want all ones", icD);
    end
    checks++;
    if (errT !== TO + 1) begin
      failures++;
      $display("FAIL timeout_err_cycle: got %0d want %0d", errT, TO + 1);
    end
    checks++;
    if (bus.mem_req !== 1'b0 || bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_idle: mem_req=%b timeout_err=%b want 0 1", bus.mem_req, bus.timeout_err);
    end
    round(1'b0, 1'b1, 32'h0, 32'h440, 1'b0, '0, 2, "after_timeout");
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    memLat = 5;
    bus.ic_addr = 32'h400;
    bus.ic_req = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy: mem_req=%b want 1", bus.mem_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.ic_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_drop: mem_req=%b ic_resp_valid=%b want 0 0", bus.mem_req, bus.ic_resp_valid);
    end
    bus.ic_req = 1'b0;
    repeat (2) begin
      tick();
      if (bus.ic_resp_valid || bus.dc_resp_valid) pulses++;
    end
    reset = 1'b0;
    repeat (6) begin
      tick();
      if (bus.ic_resp_valid || bus.dc_resp_valid) pulses++;
    end
    lastModel = OWN_IC;
    icHold = '0;
    dcHold = '0;
    checks++;
    if (pulses !== 0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: pulses=%0d timeout_err=%b want 0 0", pulses, bus.timeout_err);
    end
    round(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, '0, 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ic_refill();
    test_dc_writeback();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
